// File: rtl/maxnet_done_detect_if.sv
// -----------------------------------------------------------------------------
// maxnet_done_detect_if
// Bundles the control and activation bus between the Maxnet controller and the
// convergence detector.
//   start      : one-cycle pulse that clears state and begins a new search
//   vec_valid  : vec_in holds the activations of the current iteration
//   vec_in     : N*W packed activations, channel i at [i*W +: W]
//   busy       : detector is searching
//   done       : converged (sticky until start)
//   timeout    : iteration budget exhausted (sticky until start)
//   winner     : index of the sole surviving channel (0 when none / not done)
//   none_left  : converged with every channel at zero
//   iter_count : samples accepted since start
// master = controller side, slave = detector side.
// -----------------------------------------------------------------------------
interface maxnet_done_detect_if #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int MAX_ITER = 255
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_ITER + 1);

  logic             start;
  logic             vec_valid;
  logic [N*W-1:0]   vec_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [IDX_W-1:0] winner;
  logic             none_left;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output start, vec_valid, vec_in,
    input  busy, done, timeout, winner, none_left, iter_count
  );

  modport slave (
    input  start, vec_valid, vec_in,
    output busy, done, timeout, winner, none_left, iter_count
  );
endinterface

// File: rtl/maxnet_done_detect.sv
// -----------------------------------------------------------------------------
// maxnet_done_detect
// Convergence detector for the Maxnet datapath. On every accepted iteration
// sample it checks whether at most one activation channel is non-zero; once the
// same qualifying pattern (a particular sole survivor, or all-zero) has been
// seen STABLE consecutive times it reports done. If MAX_ITER samples go by
// without convergence it reports timeout. All outputs are registered.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : maxnet_done_detect_if slave modport (start, vec_valid, vec_in in;
//              busy, done, timeout, winner, none_left, iter_count out)
// -----------------------------------------------------------------------------
module maxnet_done_detect #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int STABLE   = 1,
  parameter int MAX_ITER = 255,
  localparam int IDX_W   = $clog2(N),
  localparam int CNT_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  maxnet_done_detect_if.slave      bus
);

  localparam int STAB_W = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_ITER);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2,
    TOUT  = 2'd3
  } state_t;

  state_t            state_r, state_nxt;
  logic [N-1:0]      mask_s;
  logic [IDX_W-1:0]  idx_s;
  logic              multi_s;
  logic              zero_s;
  logic              same_s;
  logic              converge_s;
  logic [STAB_W-1:0] stab_inc_s;
  logic [CNT_W-1:0]  iter_inc_s;

  logic [STAB_W-1:0] stab_r, stab_nxt;
  logic              prev_zero_r, prev_zero_nxt;
  logic [IDX_W-1:0]  prev_idx_r, prev_idx_nxt;
  logic [CNT_W-1:0]  iter_r, iter_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic              timeout_r, timeout_nxt;
  logic [IDX_W-1:0]  winner_r, winner_nxt;
  logic              none_left_r, none_left_nxt;

  // Per-channel activity mask and index of the (assumed sole) active channel.
  // The OR-accumulated index is only meaningful when the mask is one-hot.
  always_comb begin
    mask_s = '0;
    idx_s  = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = |bus.vec_in[i*W +: W];
      idx_s     = idx_s | (mask_s[i] ? IDX_W'(i) : '0);
    end
  end

  // Sample classification and the candidate stability / iteration counts.
  always_comb begin
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi_s    = |(mask_s & (mask_s - N'(1)));
    zero_s     = ~|mask_s;
    // A non-zero stability count means the previous sample qualified, so the
    // stored pattern is valid to compare against.
    same_s     = (stab_r != '0) && (prev_zero_r == zero_s) &&
                 (zero_s || (prev_idx_r == idx_s));
    // A changed pattern restarts the run with this sample as its first member.
    stab_inc_s = same_s ? (stab_r + STAB_W'(1)) : STAB_W'(1);
    converge_s = !multi_s && (stab_inc_s == STAB_MAX);
    iter_inc_s = (iter_r == MAX_CNT) ? iter_r : (iter_r + CNT_W'(1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_r;
    stab_nxt      = stab_r;
    prev_zero_nxt = prev_zero_r;
    prev_idx_nxt  = prev_idx_r;
    iter_nxt      = iter_r;
    busy_nxt      = busy_r;
    done_nxt      = done_r;
    timeout_nxt   = timeout_r;
    winner_nxt    = winner_r;
    none_left_nxt = none_left_r;

    if (bus.start) begin
      // start re-arms from any state; a coincident vec_valid is dropped.
      state_nxt     = CHECK;
      stab_nxt      = '0;
      prev_zero_nxt = 1'b0;
      prev_idx_nxt  = '0;
      iter_nxt      = '0;
      busy_nxt      = 1'b1;
      done_nxt      = 1'b0;
      timeout_nxt   = 1'b0;
      winner_nxt    = '0;
      none_left_nxt = 1'b0;
    end else begin
      case (state_r)
        CHECK: begin
          if (bus.vec_valid) begin
            iter_nxt = iter_inc_s;
            if (multi_s) begin
              stab_nxt = '0;
            end else begin
              stab_nxt      = stab_inc_s;
              prev_zero_nxt = zero_s;
              prev_idx_nxt  = idx_s;
            end
            // Convergence takes priority over an exhausted budget.
            if (converge_s) begin
              state_nxt     = DONE;
              busy_nxt      = 1'b0;
              done_nxt      = 1'b1;
              winner_nxt    = zero_s ? '0 : idx_s;
              none_left_nxt = zero_s;
            end else if (iter_inc_s == MAX_CNT) begin
              state_nxt   = TOUT;
              busy_nxt    = 1'b0;
              timeout_nxt = 1'b1;
            end else begin
              state_nxt = CHECK;
            end
          end else begin
            state_nxt = CHECK;
          end
        end
        default: begin
          state_nxt = state_r;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_r      <= '0;
      prev_zero_r <= 1'b0;
      prev_idx_r  <= '0;
      iter_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      winner_r    <= '0;
      none_left_r <= 1'b0;
    end else begin
      stab_r      <= stab_nxt;
      prev_zero_r <= prev_zero_nxt;
      prev_idx_r  <= prev_idx_nxt;
      iter_r      <= iter_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
      timeout_r   <= timeout_nxt;
      winner_r    <= winner_nxt;
      none_left_r <= none_left_nxt;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.timeout    = timeout_r;
  assign bus.winner     = winner_r;
  assign bus.none_left  = none_left_r;
  assign bus.iter_count = iter_r;

endmodule

// File: tb/tb_maxnet_done_detect.sv
// -----------------------------------------------------------------------------
// tb_maxnet_done_detect
// Self-checking bench for maxnet_done_detect. Four instances share one stimulus
// bus (all have a 128-bit vec_in):
//   a: N=4 W=32 STABLE=1 MAX_ITER=255
//   b: N=4 W=32 STABLE=3 MAX_ITER=255
//   c: N=4 W=32 STABLE=1 MAX_ITER=4
//   d: N=8 W=16 STABLE=1 MAX_ITER=255
// Expected outputs are queued as each stimulus cycle is driven and popped and
// compared once the following clock edge has produced the DUT response.
// -----------------------------------------------------------------------------
module tb_maxnet_done_detect;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       timeout;
    logic       none_left;
    logic [2:0] winner;
    logic [7:0] iter;
  } out_t;

  typedef struct packed {
    logic         st;
    logic         vv;
    logic [127:0] v;
    out_t         e;
  } step_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  out_t exp_q[$];

  maxnet_done_detect_if #(.N(4), .W(32), .MAX_ITER(255)) if_a ();
  maxnet_done_detect_if #(.N(4), .W(32), .MAX_ITER(255)) if_b ();
  maxnet_done_detect_if #(.N(4), .W(32), .MAX_ITER(4))   if_c ();
  maxnet_done_detect_if #(.N(8), .W(16), .MAX_ITER(255)) if_d ();

  assign if_b.start = if_a.start;  assign if_b.vec_valid = if_a.vec_valid;  assign if_b.vec_in = if_a.vec_in;
  assign if_c.start = if_a.start;  assign if_c.vec_valid = if_a.vec_valid;  assign if_c.vec_in = if_a.vec_in;
  assign if_d.start = if_a.start;  assign if_d.vec_valid = if_a.vec_valid;  assign if_d.vec_in = if_a.vec_in;

  maxnet_done_detect #(.N(4), .W(32), .STABLE(1), .MAX_ITER(255)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  maxnet_done_detect #(.N(4), .W(32), .STABLE(3), .MAX_ITER(255)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  maxnet_done_detect #(.N(4), .W(32), .STABLE(1), .MAX_ITER(4))   u_c (.clk(clk), .rst(rst), .bus(if_c));
  maxnet_done_detect #(.N(8), .W(16), .STABLE(1), .MAX_ITER(255)) u_d (.clk(clk), .rst(rst), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic b, input logic d, input logic t, input logic n,
                              input logic [2:0] w, input logic [7:0] c);
    out_t r;
    r.busy = b; r.done = d; r.timeout = t; r.none_left = n; r.winner = w; r.iter = c;
    return r;
  endfunction

  function automatic step_t stp(input logic st, input logic vv, input logic [127:0] v, input out_t e);
    step_t r;
    r.st = st; r.vv = vv; r.v = v; r.e = e;
    return r;
  endfunction

  // Channel c of a 4 x 32-bit vector set to val.
  function automatic logic [127:0] ch4(input int c, input logic [31:0] val);
    logic [127:0] r;
    r = '0;
    r[c*32 +: 32] = val;
    return r;
  endfunction

  // Channel c of an 8 x 16-bit vector set to val.
  function automatic logic [127:0] ch8(input int c, input logic [15:0] val);
    logic [127:0] r;
    r = '0;
    r[c*16 +: 16] = val;
    return r;
  endfunction

  function automatic out_t obs(input int sel);
    case (sel)
      0: return {if_a.busy, if_a.done, if_a.timeout, if_a.none_left, 1'b0, if_a.winner, if_a.iter_count};
      1: return {if_b.busy, if_b.done, if_b.timeout, if_b.none_left, 1'b0, if_b.winner, if_b.iter_count};
      2: return {if_c.busy, if_c.done, if_c.timeout, if_c.none_left, 1'b0, if_c.winner, 5'b0, if_c.iter_count};
      3: return {if_d.busy, if_d.done, if_d.timeout, if_d.none_left, if_d.winner, if_d.iter_count};
      default: return '0;
    endcase
  endfunction

  // Drive one cycle of stimulus, then advance to just after the next rising edge.
  task automatic tick(input logic st, input logic vv, input logic [127:0] v);
    if_a.start     = st;
    if_a.vec_valid = vv;
    if_a.vec_in    = v;
    @(posedge clk);
    #1;
    if_a.start     = 1'b0;
    if_a.vec_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_t o;
    for (int s = 0; s < 4; s++) begin
      o = obs(s);
      total++;
      if (o !== '0) begin bad++; $display("FAIL reset[%0d] got=%h exp=%h", s, o, out_t'(0)); end
    end
    // vec_valid without start is ignored in IDLE
    tick(1'b0, 1'b1, ch4(2, 32'h5));
    tick(1'b0, 1'b1, '0);
    for (int s = 0; s < 4; s++) begin
      o = obs(s);
      total++;
      if (o !== '0) begin bad++; $display("FAIL idle_ignore[%0d] got=%h exp=%h", s, o, out_t'(0)); end
    end
  endtask

  task automatic test_stable1();
    step_t s[5];
    out_t  e, o;
    s[0] = stp(1'b1, 1'b0, '0,                        mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[1] = stp(1'b0, 1'b1, ch4(2, 32'h5),             mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1));
    s[2] = stp(1'b1, 1'b0, '0,                        mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[3] = stp(1'b0, 1'b1, ch4(0, 32'h1) | ch4(1, 32'h2), mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[4] = stp(1'b0, 1'b1, '0,                        mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'd2));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(s[i].e);
      tick(s[i].st, s[i].vv, s[i].v);
      e = exp_q.pop_front();
      o = obs(0);
      total++;
      if (o !== e) begin bad++; $display("FAIL stable1[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_stable3();
    step_t s[18];
    out_t  e, o;
    logic [127:0] c0, c1, c3, mh;
    c0 = ch4(0, 32'h9); c1 = ch4(1, 32'h1); c3 = ch4(3, 32'h80000000);
    mh = ch4(1, 32'h1) | ch4(2, 32'h1);
    // winner changes from ch1 to ch3: the run restarts at the first ch3
    s[0]  = stp(1'b1, 1'b0, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[1]  = stp(1'b0, 1'b1, c1, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[2]  = stp(1'b0, 1'b1, c1, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2));
    s[3]  = stp(1'b0, 1'b1, c3, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3));
    s[4]  = stp(1'b0, 1'b1, c3, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd4));
    s[5]  = stp(1'b0, 1'b1, c3, mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'd5));
    // multi-hot in the middle of a ch1 run
    s[6]  = stp(1'b1, 1'b0, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[7]  = stp(1'b0, 1'b1, c1, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[8]  = stp(1'b0, 1'b1, c1, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2));
    s[9]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3));
    s[10] = stp(1'b0, 1'b1, c1, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd4));
    s[11] = stp(1'b0, 1'b1, c1, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd5));
    s[12] = stp(1'b0, 1'b1, c1, mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd6));
    // switch from one-hot to all-zero restarts the run
    s[13] = stp(1'b1, 1'b0, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[14] = stp(1'b0, 1'b1, c0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[15] = stp(1'b0, 1'b1, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2));
    s[16] = stp(1'b0, 1'b1, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3));
    s[17] = stp(1'b0, 1'b1, '0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'd4));
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(s[i].e);
      tick(s[i].st, s[i].vv, s[i].v);
      e = exp_q.pop_front();
      o = obs(1);
      total++;
      if (o !== e) begin bad++; $display("FAIL stable3[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_timeout();
    step_t s[11];
    out_t  e, o;
    logic [127:0] mh;
    mh = ch4(0, 32'h3) | ch4(3, 32'h1);
    s[0]  = stp(1'b1, 1'b0, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[1]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[2]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2));
    s[3]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3));
    s[4]  = stp(1'b0, 1'b1, mh, mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd4));
    s[5]  = stp(1'b0, 1'b1, ch4(2, 32'h1), mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd4));
    s[6]  = stp(1'b1, 1'b0, '0, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[7]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[8]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2));
    s[9]  = stp(1'b0, 1'b1, mh, mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3));
    s[10] = stp(1'b0, 1'b1, ch4(0, 32'h7), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd4));
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(s[i].e);
      tick(s[i].st, s[i].vv, s[i].v);
      e = exp_q.pop_front();
      o = obs(2);
      total++;
      if (o !== e) begin bad++; $display("FAIL timeout[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_sticky_restart();
    step_t s[8];
    out_t  e, o;
    s[0] = stp(1'b1, 1'b0, '0,            mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[1] = stp(1'b0, 1'b1, ch4(1, 32'h4), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1));
    s[2] = stp(1'b0, 1'b1, ch4(3, 32'h4), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1));
    s[3] = stp(1'b0, 1'b1, ch4(0, 32'h1) | ch4(3, 32'h1), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1));
    s[4] = stp(1'b0, 1'b1, '0,            mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1));
    s[5] = stp(1'b1, 1'b1, ch4(2, 32'h1), mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[6] = stp(1'b0, 1'b0, ch4(2, 32'h1), mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[7] = stp(1'b0, 1'b1, ch4(2, 32'h1), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(s[i].e);
      tick(s[i].st, s[i].vv, s[i].v);
      e = exp_q.pop_front();
      o = obs(0);
      total++;
      if (o !== e) begin bad++; $display("FAIL sticky[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_async_reset();
    out_t e, o;
    tick(1'b1, 1'b0, '0);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    tick(1'b0, 1'b1, ch4(0, 32'h1) | ch4(2, 32'h1));
    e = exp_q.pop_front();
    o = obs(0);
    total++;
    if (o !== e) begin bad++; $display("FAIL areset_pre got=%h exp=%h", o, e); end
    // assert reset between edges; outputs must clear without a clock edge
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      o = obs(s);
      total++;
      if (o !== '0) begin bad++; $display("FAIL areset_now[%0d] got=%h exp=%h", s, o, out_t'(0)); end
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    o = obs(0);
    total++;
    if (o !== '0) begin bad++; $display("FAIL areset_after got=%h exp=%h", o, out_t'(0)); end
  endtask

  task automatic test_n8();
    step_t s[5];
    out_t  e, o;
    s[0] = stp(1'b1, 1'b0, '0,               mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[1] = stp(1'b0, 1'b1, ch8(7, 16'h8000), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 8'd1));
    s[2] = stp(1'b1, 1'b0, '0,               mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0));
    s[3] = stp(1'b0, 1'b1, ch8(0, 16'h1) | ch8(7, 16'h1), mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1));
    s[4] = stp(1'b0, 1'b1, ch8(5, 16'h0100), mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'd2));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(s[i].e);
      tick(s[i].st, s[i].vv, s[i].v);
      e = exp_q.pop_front();
      o = obs(3);
      total++;
      if (o !== e) begin bad++; $display("FAIL n8[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if_a.start     = 1'b0;
    if_a.vec_valid = 1'b0;
    if_a.vec_in    = '0;
    #23 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stable1();
    test_stable3();
    test_timeout();
    test_sticky_restart();
    test_async_reset();
    test_n8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
